// File: rtl/wt_dcache_inval_sched_if.sv
// Port bundle of the dcache invalidation scheduler: bus source, range source,
// invalidation-unit port and status. slave = scheduler side, master = environment.
interface wt_dcache_inval_sched_if #(
  parameter int unsigned PLEN            = 56,
  parameter int unsigned RANGE_CNT_WIDTH = 16
);
  logic                       bus_inv_vld_i;
  logic [PLEN-1:0]            bus_inv_paddr_i;
  logic                       bus_inv_rdy_o;
  logic                       rng_vld_i;
  logic [PLEN-1:0]            rng_paddr_i;
  logic [RANGE_CNT_WIDTH-1:0] rng_cnt_i;
  logic                       rng_rdy_o;
  logic                       rng_done_o;
  logic                       mem_inv_req_o;
  logic [PLEN-1:0]            mem_inv_paddr_o;
  logic                       mem_inv_ack_i;
  logic                       busy_o;

  modport slave (
    input  bus_inv_vld_i, bus_inv_paddr_i, rng_vld_i, rng_paddr_i, rng_cnt_i, mem_inv_ack_i,
    output bus_inv_rdy_o, rng_rdy_o, rng_done_o, mem_inv_req_o, mem_inv_paddr_o, busy_o
  );

  modport master (
    output bus_inv_vld_i, bus_inv_paddr_i, rng_vld_i, rng_paddr_i, rng_cnt_i, mem_inv_ack_i,
    input  bus_inv_rdy_o, rng_rdy_o, rng_done_o, mem_inv_req_o, mem_inv_paddr_o, busy_o
  );
endinterface

// File: rtl/wt_dcache_inval_sched.sv
// Round-robin invalidation scheduler: bus FIFO + range walker onto one req/ack port.
// Optional `WT_DCACHE_INVAL_MERGE_EN drops bus invalidations already queued.
module wt_dcache_inval_sched #(
  parameter int unsigned PLEN            = 56,
  parameter int unsigned OFFSET_WIDTH    = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned RANGE_CNT_WIDTH = 16
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  wt_dcache_inval_sched_if.slave sched
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PLEN-1:0] LINE_MASK  = {{(PLEN-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};
  localparam logic [PLEN-1:0] LINE_BYTES = {{(PLEN-1){1'b0}}, 1'b1} << OFFSET_WIDTH;

  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DONE} r_state_e;
  typedef enum logic       {O_IDLE, O_REQ}         o_state_e;
  typedef enum logic       {SRC_FIFO, SRC_WALK}    src_e;

  logic [PLEN-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full, push, pop, bus_rdy;
  logic [PLEN-1:0]  bus_line;

  r_state_e                   r_state_q, r_state_d;
  logic [PLEN-1:0]            addr_q, addr_d;
  logic [RANGE_CNT_WIDTH-1:0] rem_q, rem_d;

  o_state_e        o_state_q, o_state_d;
  src_e            src_q, src_d;
  logic [PLEN-1:0] paddr_q, paddr_d;
  logic            rr_q, rr_d;
  logic            ack_fire, walk_adv, fifo_cand, walk_cand;

  assign bus_line  = sched.bus_inv_paddr_i & LINE_MASK;
  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign ack_fire  = (o_state_q == O_REQ) && sched.mem_inv_ack_i;
  assign pop       = ack_fire && (src_q == SRC_FIFO);
  assign walk_adv  = ack_fire && (src_q == SRC_WALK);
  assign fifo_cand = (cnt_q != '0);
  assign walk_cand = (r_state_q == R_RUN);

`ifdef WT_DCACHE_INVAL_MERGE_EN
  logic             inflight_fifo, match;
  logic [PTR_W-1:0] off;

  assign inflight_fifo = (o_state_q == O_REQ) && (src_q == SRC_FIFO);

  // The in-flight head is about to be popped, so it must not absorb a new request.
  always_comb begin
    match = 1'b0;
    off   = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(off) < cnt_q) && !((off == '0) && inflight_fifo) && (fifo_mem[i] == bus_line))
        match = 1'b1;
    end
  end

  assign bus_rdy = !full || match;
  assign push    = sched.bus_inv_vld_i && bus_rdy && !match;
`else
  assign bus_rdy = !full;
  assign push    = sched.bus_inv_vld_i && !full;
`endif

  // NOTE: storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= bus_line;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    r_state_d = r_state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    case (r_state_q)
      R_IDLE: if (sched.rng_vld_i) begin
        if (sched.rng_cnt_i == '0) begin
          r_state_d = R_DONE;
        end else begin
          addr_d    = sched.rng_paddr_i & LINE_MASK;
          rem_d     = sched.rng_cnt_i;
          r_state_d = R_RUN;
        end
      end
      R_RUN: if (walk_adv) begin
        addr_d = addr_q + LINE_BYTES;
        rem_d  = rem_q - RANGE_CNT_WIDTH'(1);
        if (rem_q == RANGE_CNT_WIDTH'(1)) r_state_d = R_DONE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    o_state_d = o_state_q;
    src_d     = src_q;
    paddr_d   = paddr_q;
    rr_d      = rr_q;
    case (o_state_q)
      O_IDLE: begin
        if (fifo_cand && (!walk_cand || !rr_q)) begin
          src_d     = SRC_FIFO;
          paddr_d   = fifo_mem[rd_ptr_q];
          o_state_d = O_REQ;
        end else if (walk_cand) begin
          src_d     = SRC_WALK;
          paddr_d   = addr_q;
          o_state_d = O_REQ;
        end
      end
      default: if (sched.mem_inv_ack_i) begin
        rr_d      = (src_q == SRC_FIFO);
        o_state_d = O_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      o_state_q <= O_IDLE;
      src_q     <= SRC_FIFO;
      paddr_q   <= '0;
      rr_q      <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      o_state_q <= o_state_d;
      src_q     <= src_d;
      paddr_q   <= paddr_d;
      rr_q      <= rr_d;
    end
  end

  assign sched.bus_inv_rdy_o   = bus_rdy;
  assign sched.rng_rdy_o       = (r_state_q == R_IDLE);
  assign sched.rng_done_o      = (r_state_q == R_DONE);
  assign sched.mem_inv_req_o   = (o_state_q == O_REQ);
  assign sched.mem_inv_paddr_o = paddr_q;
  assign sched.busy_o          = fifo_cand || (r_state_q != R_IDLE) || (o_state_q == O_REQ);
endmodule

// File: tb/tb_wt_dcache_inval_sched.sv
// Bench for wt_dcache_inval_sched: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based transaction model.
module tb_wt_dcache_inval_sched;
  localparam int unsigned PLEN  = 56;
  localparam int unsigned OW    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;
  typedef logic [PLEN-1:0] addr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wt_dcache_inval_sched_if #(.PLEN(PLEN), .RANGE_CNT_WIDTH(CW)) bus_if ();

  wt_dcache_inval_sched #(
    .PLEN(PLEN), .OFFSET_WIDTH(OW), .FIFO_DEPTH(DEPTH), .RANGE_CNT_WIDTH(CW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sched (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int samp_cyc = 0;

  addr_t issued_q[$];
  int    issued_cyc_q[$];
  int    done_cnt, last_done_cyc;
  bit    req_seen;

  logic  obs_req, obs_bus_rdy, obs_rng_rdy, obs_done, obs_busy;
  addr_t obs_paddr;
  logic  e_req, e_bus_rdy, e_rng_rdy, e_done, e_busy;
  addr_t e_paddr;

  // Transaction model: pending bus lines, pending walker lines, one outstanding request.
  addr_t m_bus_q[$];
  addr_t m_walk_q[$];
  bit    m_req, m_src_walk, m_rr_walk, m_rng_busy, m_done;
  addr_t m_paddr;

  function automatic addr_t align(addr_t a);
    addr_t low;
    low = addr_t'((1 << OW) - 1);
    return a & ~low;
  endfunction

  task automatic model_reset();
    m_bus_q.delete();
    m_walk_q.delete();
    m_req = 0; m_src_walk = 0; m_rr_walk = 0; m_rng_busy = 0; m_done = 0;
    m_paddr = '0;
  endtask

  task automatic clear_inputs();
    bus_if.bus_inv_vld_i   = 1'b0;
    bus_if.bus_inv_paddr_i = '0;
    bus_if.rng_vld_i       = 1'b0;
    bus_if.rng_paddr_i     = '0;
    bus_if.rng_cnt_i       = '0;
    bus_if.mem_inv_ack_i   = 1'b0;
  endtask

  task automatic clear_logs();
    issued_q.delete();
    issued_cyc_q.delete();
    done_cnt = 0; last_done_cyc = -100; req_seen = 0;
  endtask

  // Advance one clock: sample DUT and model at the falling edge, then update the model.
  task automatic step();
    bit nxt_done;
    @(negedge clk);
    samp_cyc    = cyc;
    obs_req     = bus_if.mem_inv_req_o;
    obs_paddr   = bus_if.mem_inv_paddr_o;
    obs_bus_rdy = bus_if.bus_inv_rdy_o;
    obs_rng_rdy = bus_if.rng_rdy_o;
    obs_done    = bus_if.rng_done_o;
    obs_busy    = bus_if.busy_o;
    e_req       = m_req;
    e_paddr     = m_paddr;
    e_bus_rdy   = (m_bus_q.size() < DEPTH);
    e_rng_rdy   = !m_rng_busy && !m_done;
    e_done      = m_done;
    e_busy      = (m_bus_q.size() > 0) || m_rng_busy || m_done || m_req;
    if (obs_req === 1'b1) req_seen = 1;
    if (obs_req === 1'b1 && bus_if.mem_inv_ack_i) begin
      issued_q.push_back(obs_paddr);
      issued_cyc_q.push_back(samp_cyc);
    end
    if (obs_done === 1'b1) begin done_cnt++; last_done_cyc = samp_cyc; end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      nxt_done = 0;
      if (m_req) begin
        if (bus_if.mem_inv_ack_i) begin
          if (m_src_walk) begin
            void'(m_walk_q.pop_front());
            m_rr_walk = 0;
            if (m_walk_q.size() == 0) begin m_rng_busy = 0; nxt_done = 1; end
          end else begin
            void'(m_bus_q.pop_front());
            m_rr_walk = 1;
          end
          m_req = 0;
        end
      end else if (m_bus_q.size() > 0 && (m_walk_q.size() == 0 || !m_rr_walk)) begin
        m_req = 1; m_src_walk = 0; m_paddr = m_bus_q[0];
      end else if (m_walk_q.size() > 0) begin
        m_req = 1; m_src_walk = 1; m_paddr = m_walk_q[0];
      end
      if (bus_if.bus_inv_vld_i && e_bus_rdy) m_bus_q.push_back(align(bus_if.bus_inv_paddr_i));
      if (bus_if.rng_vld_i && e_rng_rdy) begin
        if (bus_if.rng_cnt_i == '0) nxt_done = 1;
        else begin
          for (int i = 0; i < int'(bus_if.rng_cnt_i); i++)
            m_walk_q.push_back(align(bus_if.rng_paddr_i) + addr_t'(i) * addr_t'(1 << OW));
          m_rng_busy = 1;
        end
      end
      m_done = nxt_done;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus_if.bus_inv_vld_i = 1'b1; bus_if.bus_inv_paddr_i = addr_t'(32'h1230);
    bus_if.rng_vld_i = 1'b1; bus_if.rng_cnt_i = CW'(3);
    step();
    rst_n = 1'b1;
    clear_inputs();
    step();
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", obs_req); end
    n_checks++; if (obs_paddr !== '0) begin n_fail++; $display("FAIL reset_paddr: got %h want 0", obs_paddr); end
    n_checks++; if (obs_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", obs_done); end
    n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", obs_busy); end
    n_checks++; if (obs_bus_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_bus_rdy: got %b want 1", obs_bus_rdy); end
    n_checks++; if (obs_rng_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rng_rdy: got %b want 1", obs_rng_rdy); end
  endtask

  task automatic test_single_bus();
    do_reset();
    bus_if.bus_inv_vld_i = 1'b1; bus_if.bus_inv_paddr_i = addr_t'(32'h8000_1234);
    step();                                   // T: push
    bus_if.bus_inv_vld_i = 1'b0;
    step();                                   // T+1: selection
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL single_req_t1: got %b want 0", obs_req); end
    for (int k = 2; k <= 4; k++) begin
      bus_if.mem_inv_ack_i = (k == 4);
      step();
      n_checks++; if (obs_req !== 1'b1) begin n_fail++; $display("FAIL single_req_t%0d: got %b want 1", k, obs_req); end
      n_checks++; if (obs_paddr !== addr_t'(32'h8000_1230)) begin
        n_fail++; $display("FAIL single_paddr_t%0d: got %h want 80001230", k, obs_paddr); end
    end
    bus_if.mem_inv_ack_i = 1'b0;
    step();                                   // T+5
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL single_req_t5: got %b want 0", obs_req); end
    n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_t5: got %b want 0", obs_busy); end
  endtask

  task automatic test_range();
    addr_t exp [3];
    logic  rdy_after;
    exp[0] = addr_t'(32'h8000_0000); exp[1] = addr_t'(32'h8000_0010); exp[2] = addr_t'(32'h8000_0020);
    rdy_after = 1'bx;
    do_reset();
    bus_if.rng_vld_i = 1'b1; bus_if.rng_paddr_i = addr_t'(32'h8000_0008); bus_if.rng_cnt_i = CW'(3);
    step();
    bus_if.rng_vld_i = 1'b0;
    obs_req = 1'b0;
    for (int k = 0; k < 30; k++) begin
      bus_if.mem_inv_ack_i = obs_req;
      step();
      if (samp_cyc == last_done_cyc + 1) rdy_after = obs_rng_rdy;
    end
    bus_if.mem_inv_ack_i = 1'b0;
    n_checks++; if (issued_q.size() != 3) begin n_fail++; $display("FAIL range_count: got %0d want 3", issued_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (i >= issued_q.size() || issued_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL range_addr%0d: got %h want %h", i, (i < issued_q.size()) ? issued_q[i] : addr_t'('x), exp[i]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL range_done_pulses: got %0d want 1", done_cnt); end
    n_checks++; if (issued_cyc_q.size() != 3 || last_done_cyc != issued_cyc_q[2] + 1) begin
      n_fail++; $display("FAIL range_done_cycle: got %0d want one after last ack", last_done_cyc); end
    n_checks++; if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL range_rdy_after_done: got %b want 1", rdy_after); end
  endtask

  task automatic test_range_zero();
    int t;
    do_reset();
    bus_if.rng_vld_i = 1'b1; bus_if.rng_paddr_i = addr_t'(32'h5000); bus_if.rng_cnt_i = '0;
    step();
    t = samp_cyc;
    bus_if.rng_vld_i = 1'b0; bus_if.mem_inv_ack_i = 1'b1;
    for (int k = 0; k < 8; k++) step();
    bus_if.mem_inv_ack_i = 1'b0;
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end
    n_checks++; if (last_done_cyc != t + 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want %0d", last_done_cyc, t + 1); end
    n_checks++; if (req_seen) begin n_fail++; $display("FAIL zero_no_req: got req want none"); end
  endtask

  task automatic test_range_wrap();
    addr_t base;
    addr_t exp [4];
    base = addr_t'('1) - addr_t'(47);        // ...FFD0
    exp[0] = base; exp[1] = base + addr_t'(16); exp[2] = addr_t'('1) - addr_t'(15); exp[3] = '0;
    do_reset();
    bus_if.rng_vld_i = 1'b1; bus_if.rng_paddr_i = base + addr_t'(7); bus_if.rng_cnt_i = CW'(4);
    step();
    bus_if.rng_vld_i = 1'b0; bus_if.mem_inv_ack_i = 1'b1;
    for (int k = 0; k < 20; k++) step();
    bus_if.mem_inv_ack_i = 1'b0;
    n_checks++; if (issued_q.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", issued_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (i >= issued_q.size() || issued_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, (i < issued_q.size()) ? issued_q[i] : addr_t'('x), exp[i]); end
    end
  endtask

  task automatic test_interleave();
    addr_t exp [4];
    exp[0] = addr_t'(32'h100); exp[1] = addr_t'(32'h1000); exp[2] = addr_t'(32'h200); exp[3] = addr_t'(32'h1010);
    do_reset();
    bus_if.mem_inv_ack_i = 1'b1;
    bus_if.bus_inv_vld_i = 1'b1; bus_if.bus_inv_paddr_i = exp[0];
    bus_if.rng_vld_i = 1'b1; bus_if.rng_paddr_i = exp[1]; bus_if.rng_cnt_i = CW'(2);
    step();
    bus_if.bus_inv_paddr_i = exp[2]; bus_if.rng_vld_i = 1'b0;
    step();
    bus_if.bus_inv_vld_i = 1'b0;
    for (int k = 0; k < 20; k++) step();
    bus_if.mem_inv_ack_i = 1'b0;
    n_checks++; if (issued_q.size() != 4) begin n_fail++; $display("FAIL rr_count: got %0d want 4", issued_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (i >= issued_q.size() || issued_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL rr_order%0d: got %h want %h", i, (i < issued_q.size()) ? issued_q[i] : addr_t'('x), exp[i]); end
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus_if.bus_inv_vld_i = 1'b1; bus_if.bus_inv_paddr_i = addr_t'(32'h4000 + i * 32'h40);
      step();
      n_checks++; if (obs_bus_rdy !== 1'b1) begin n_fail++; $display("FAIL full_rdy_push%0d: got %b want 1", i, obs_bus_rdy); end
    end
    bus_if.bus_inv_paddr_i = addr_t'(32'h4100);
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (obs_bus_rdy !== 1'b0) begin n_fail++; $display("FAIL full_rdy_held%0d: got %b want 0", k, obs_bus_rdy); end
    end
    bus_if.mem_inv_ack_i = 1'b1;
    step();
    n_checks++; if (obs_req !== 1'b1 || obs_bus_rdy !== 1'b0) begin
      n_fail++; $display("FAIL full_ack_cycle: got req=%b rdy=%b want req=1 rdy=0", obs_req, obs_bus_rdy); end
    bus_if.mem_inv_ack_i = 1'b0;
    step();
    n_checks++; if (obs_bus_rdy !== 1'b1) begin n_fail++; $display("FAIL full_rdy_after_pop: got %b want 1", obs_bus_rdy); end
    bus_if.bus_inv_vld_i = 1'b0; bus_if.mem_inv_ack_i = 1'b1;
    for (int k = 0; k < 20; k++) step();
    bus_if.mem_inv_ack_i = 1'b0;
    n_checks++; if (issued_q.size() != 5) begin n_fail++; $display("FAIL full_count: got %0d want 5", issued_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (i >= issued_q.size() || issued_q[i] !== addr_t'(32'h4000 + i * 32'h40)) begin
        n_fail++; $display("FAIL full_order%0d: got %h want %h", i, (i < issued_q.size()) ? issued_q[i] : addr_t'('x),
                           addr_t'(32'h4000 + i * 32'h40)); end
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    do_reset();
    bus_if.rng_vld_i = 1'b1; bus_if.rng_paddr_i = addr_t'(32'h2000); bus_if.rng_cnt_i = CW'(10);
    step();
    bus_if.rng_vld_i = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      bus_if.mem_inv_ack_i = (issued_q.size() < 2);
      step();
      if (issued_q.size() == 2 && obs_req === 1'b1 && !bus_if.mem_inv_ack_i) hit = 1;
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL midrst_third_req: got timeout want third request in flight"); end
    bus_if.mem_inv_ack_i = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    done_cnt = 0; req_seen = 0;
    step();
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b want 0", obs_req); end
    n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", obs_busy); end
    n_checks++; if (obs_rng_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_rng_rdy: got %b want 1", obs_rng_rdy); end
    for (int k = 0; k < 6; k++) step();
    n_checks++; if (done_cnt != 0 || req_seen) begin
      n_fail++; $display("FAIL midrst_quiet: got done=%0d req_seen=%0b want 0/0", done_cnt, req_seen); end
  endtask

  task automatic test_merge();
    bit    hit;
    int    want;
    addr_t exp [3];
    exp[0] = addr_t'(32'h100); exp[1] = addr_t'(32'h300); exp[2] = addr_t'(32'h300);
`ifdef WT_DCACHE_INVAL_MERGE_EN
    want = 2;
`else
    want = 3;
`endif
    hit = 0;
    do_reset();
    bus_if.bus_inv_vld_i = 1'b1; bus_if.bus_inv_paddr_i = exp[0];
    step();
    bus_if.bus_inv_vld_i = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin step(); if (obs_req === 1'b1) hit = 1; end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL merge_first_req: got timeout want request"); end
    bus_if.bus_inv_vld_i = 1'b1; bus_if.bus_inv_paddr_i = addr_t'(32'h300);
    step();
    bus_if.bus_inv_paddr_i = addr_t'(32'h304);
    step();
    n_checks++; if (obs_bus_rdy !== 1'b1) begin n_fail++; $display("FAIL merge_dup_rdy: got %b want 1", obs_bus_rdy); end
    bus_if.bus_inv_vld_i = 1'b0; bus_if.mem_inv_ack_i = 1'b1;
    for (int k = 0; k < 20; k++) step();
    bus_if.mem_inv_ack_i = 1'b0;
    n_checks++; if (issued_q.size() != want) begin n_fail++; $display("FAIL merge_count: got %0d want %0d", issued_q.size(), want); end
    for (int i = 0; i < want; i++) begin
      n_checks++; if (i >= issued_q.size() || issued_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL merge_addr%0d: got %h want %h", i, (i < issued_q.size()) ? issued_q[i] : addr_t'('x), exp[i]); end
    end
  endtask

  task automatic test_random();
    int bcnt;
    bcnt = 0;
    do_reset();
    for (int k = 0; k < 700; k++) begin
      if (k < 500) begin
        bus_if.bus_inv_vld_i   = ($urandom_range(0, 2) == 0);
        bus_if.bus_inv_paddr_i = addr_t'(32'h0010_0000) + addr_t'(bcnt) * addr_t'(64) + addr_t'($urandom_range(0, 63));
        bus_if.rng_vld_i       = ($urandom_range(0, 7) == 0);
        bus_if.rng_paddr_i     = addr_t'(32'h8000_0000) + addr_t'($urandom_range(0, 255)) * addr_t'(4096)
                                 + addr_t'($urandom_range(0, 4095));
        bus_if.rng_cnt_i       = CW'($urandom_range(0, 5));
        bus_if.mem_inv_ack_i   = ($urandom_range(0, 2) != 0);
        bcnt++;
      end else begin
        clear_inputs();
        bus_if.mem_inv_ack_i = ($urandom_range(0, 1) != 0);
      end
      step();
      n_checks++; if (obs_req !== e_req) begin n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", samp_cyc, obs_req, e_req); end
      n_checks++; if (obs_paddr !== e_paddr) begin n_fail++; $display("FAIL rnd_paddr@%0d: got %h want %h", samp_cyc, obs_paddr, e_paddr); end
      n_checks++; if (obs_bus_rdy !== e_bus_rdy) begin n_fail++; $display("FAIL rnd_bus_rdy@%0d: got %b want %b", samp_cyc, obs_bus_rdy, e_bus_rdy); end
      n_checks++; if (obs_rng_rdy !== e_rng_rdy) begin n_fail++; $display("FAIL rnd_rng_rdy@%0d: got %b want %b", samp_cyc, obs_rng_rdy, e_rng_rdy); end
      n_checks++; if (obs_done !== e_done) begin n_fail++; $display("FAIL rnd_done@%0d: got %b want %b", samp_cyc, obs_done, e_done); end
      n_checks++; if (obs_busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", samp_cyc, obs_busy, e_busy); end
    end
    n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL rnd_drained: got busy=%b want 0", obs_busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    clear_logs();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_bus();
    test_range();
    test_range_zero();
    test_range_wrap();
    test_interleave();
    test_fifo_full();
    test_reset_mid();
    test_merge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/wt_dcache_inval_sched.md
Name: wt_dcache_inval_sched

Overview:
Scheduler in front of the write-through dcache invalidation unit. It arbitrates between two sources and drives that unit's single req/paddr/ack invalidation port:
- bus coherence invalidations, buffered in a small FIFO;
- software range-invalidate commands, expanded line by line by an internal walker.

It issues one invalidation at a time, holds it stable until acked, and round-robins between the sources.

Parameters:
PLEN, riscv::PLEN (56), physical address width
OFFSET_WIDTH, ariane_pkg::DCACHE_OFFSET_WIDTH (4), log2 of the line size in bytes
FIFO_DEPTH, 4, bus invalidation FIFO entries (power of 2, at least 2)
RANGE_CNT_WIDTH, 16, width of the range line count

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
bus_inv_vld_i  in  1  bus invalidation valid
bus_inv_paddr_i  in  PLEN  bus invalidation address
bus_inv_rdy_o  out  1  bus invalidation accepted when vld and rdy are both high
rng_vld_i  in  1  range command valid
rng_paddr_i  in  PLEN  range start address
rng_cnt_i  in  RANGE_CNT_WIDTH  number of lines in the range
rng_rdy_o  out  1  range command accepted when vld and rdy are both high
rng_done_o  out  1  one-cycle pulse when a range command completes
mem_inv_req_o  out  1  request to the invalidation unit
mem_inv_paddr_o  out  PLEN  line-aligned address; low OFFSET_WIDTH bits are 0
mem_inv_ack_i  in  1  invalidation unit ack; may arrive in the same cycle req is first seen
busy_o  out  1  FIFO non-empty, walker not idle, or a request outstanding

Behaviour:
- Reset (rst_ni low at a clock edge):
  - FIFO emptied, walker set to R_IDLE, output FSM set to O_IDLE, rr_q set to 0.
  - Output values: mem_inv_req_o=0, mem_inv_paddr_o=0, rng_done_o=0, busy_o=0, bus_inv_rdy_o=1, rng_rdy_o=1.
  - Reset mid-operation discards queued and in-flight work. No done pulse is generated. req drops at that edge.
- Alignment: all addresses are stored with bits [OFFSET_WIDTH-1:0] cleared.
- FIFO:
  - bus_inv_rdy_o = !full.
  - Push on vld and rdy.
  - The head is only peeked while in flight; it is popped on the ack of a FIFO-sourced request.
  - Push and pop in the same cycle leaves the count unchanged.
  - There is no bypass: a push is visible the next cycle.
- Range walker FSM (R_IDLE, R_RUN, R_DONE):
  - rng_rdy_o = (state == R_IDLE).
  - On accept with cnt=0, go to R_DONE. Otherwise load addr (aligned rng_paddr_i) and rem=cnt, then go to R_RUN.
  - In R_RUN the walker offers addr as a candidate.
  - On the ack of a walker-sourced request: addr += 2^OFFSET_WIDTH (wraps modulo 2^PLEN) and rem -= 1. If rem was 1, go to R_DONE.
  - R_DONE asserts rng_done_o for exactly one cycle, then returns to R_IDLE.
- Output FSM (O_IDLE, O_REQ):
  - In O_IDLE with at least one candidate, pick one source:
    - rr_q=0 prefers the FIFO, rr_q=1 prefers the walker;
    - a lone candidate always wins.
  - Latch the chosen address and source, then go to O_REQ. mem_inv_req_o is registered, so it asserts the cycle after selection.
  - In O_REQ, req and paddr stay stable until mem_inv_ack_i. On ack:
    - pop the FIFO or advance the walker;
    - set rr_q to the non-granted source;
    - return to O_IDLE, so req is low the next cycle.
  - Consequence: at most one outstanding request, and at least one idle cycle between requests.
- Latency: bus push at cycle T, selection at T+1, mem_inv_req_o high at T+2.
- busy_o is combinational from state and FIFO count.

Optional Feature:
WT_DCACHE_INVAL_MERGE_EN.
- Defined: an incoming bus invalidation whose aligned line address equals any valid FIFO entry is accepted but not enqueued.
  - The head entry is excluded from the match while it is in flight.
  - bus_inv_rdy_o = !full | match, so a matching request is accepted even when the FIFO is full.
- Not defined: every accepted request is enqueued, and bus_inv_rdy_o = !full.

Test Plan:
1. Bus push 0x8000_1234 at T, ack at T+4 -> req high T+2..T+4 with paddr 0x8000_1230; req low at T+5; busy_o 0 at T+5.
2. Range start 0x8000_0008, cnt=3, each request acked after 1 cycle -> requests 0x8000_0000, 0x8000_0010, 0x8000_0020 in order; rng_done_o one pulse the cycle after the third ack; rng_rdy_o high again after that.
3. Two bus entries A=0x100, B=0x200 queued plus range 0x1000 cnt=2 -> issue order 0x100, 0x1000, 0x200, 0x1010.
4. FIFO_DEPTH=4 with ack held low, 5 distinct pushes -> rdy low after the 4th push; the 5th is accepted only after the first ack pops the head.
5. Range cnt=0 accepted at T -> rng_done_o high only at T+1; mem_inv_req_o never asserted.
6. Range cnt=10, rst_ni low after 2 acks -> req low at the next edge; no done pulse; busy_o=0. With MERGE_EN, push 0x300 twice while 0x100 is in flight -> only one 0x300 request issued.
